// File: rtl/instr_decode_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads and writes the
// 32x32 register file and registers the result into the decode->exec stage.
module instr_decode_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_fetch,
    input  logic [XLEN-1:0] pc_fetch,
    input  logic [XLEN-1:0] next_pc_fetch,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data_exec,
    output logic [XLEN-1:0] rs2_data_exec,
    output logic [XLEN-1:0] imm_exec,
    output logic [4:0]      rs1_exec,
    output logic [4:0]      rs2_exec,
    output logic [4:0]      rd_exec,
    output logic [XLEN-1:0] pc_exec,
    output logic [XLEN-1:0] next_pc_exec,
    output logic [2:0]      funct3_exec,
    output logic [3:0]      alu_ctrl_exec,
    output logic            alu_src_a_exec,
    output logic            alu_src_b_exec,
    output logic            reg_write_exec,
    output logic            mem_read_exec,
    output logic            mem_write_exec,
    output logic            branch_exec,
    output logic            jump_exec,
    output logic [1:0]      result_src_exec,
    output logic            valid_exec,
    output logic            illegal_exec
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_NPC    = 2'b10;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic [3:0]      dec_alu;
    logic            dec_src_a;
    logic            dec_src_b;
    logic            dec_reg_write;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_branch;
    logic            dec_jump;
    logic [1:0]      dec_result_src;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;
    logic            dec_illegal;

    assign opcode = instr_fetch[6:0];
    assign funct3 = instr_fetch[14:12];
    assign funct7 = instr_fetch[31:25];
    assign rs1    = instr_fetch[19:15];
    assign rs2    = instr_fetch[24:20];
    assign rd     = instr_fetch[11:7];

    assign imm_i = {{(XLEN-12){instr_fetch[31]}}, instr_fetch[31:20]};
    assign imm_s = {{(XLEN-12){instr_fetch[31]}}, instr_fetch[31:25], instr_fetch[11:7]};
    assign imm_b = {{(XLEN-12){instr_fetch[31]}}, instr_fetch[7], instr_fetch[30:25],
                    instr_fetch[11:8], 1'b0};
    assign imm_u = XLEN'({instr_fetch[31:12], 12'b0});
    assign imm_j = {{(XLEN-20){instr_fetch[31]}}, instr_fetch[19:12], instr_fetch[20],
                    instr_fetch[30:21], 1'b0};

    // ALU operation implied by funct3 alone; SUB/SRA variants are layered on top
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    base_alu = ALU_ADD;
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Register file write port; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand read with same-cycle writeback bypass so exec never sees a stale value
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_en && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_en && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
    end

    // Main decoder: control, immediate selection and legality per opcode/funct
    always_comb begin
        dec_alu        = ALU_ADD;
        dec_src_a      = 1'b0;
        dec_src_b      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_result_src = RES_ALU;
        dec_imm        = '0;
        dec_rd         = rd;
        dec_illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_reg_write = 1'b1;
                dec_alu       = base_alu(funct3);
                if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0)      dec_alu = ALU_SUB;
                    else if (funct3 == 3'd5) dec_alu = ALU_SRA;
                    else                     dec_illegal = 1'b1;
                end else if (funct7 != 7'h00) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_reg_write = 1'b1;
                dec_src_b     = 1'b1;
                dec_imm       = imm_i;
                dec_alu       = base_alu(funct3);
                if (funct3 == 3'd1 && funct7 != 7'h00) begin
                    dec_illegal = 1'b1;
                end
                if (funct3 == 3'd5) begin
                    if (funct7 == 7'h20)      dec_alu = ALU_SRA;
                    else if (funct7 != 7'h00) dec_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_src_b      = 1'b1;
                dec_imm        = imm_i;
                dec_result_src = RES_MEM;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_mem_write = 1'b1;
                dec_src_b     = 1'b1;
                dec_imm       = imm_s;
                dec_rd        = 5'd0;
                if (funct3 > 3'd2) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu    = ALU_SUB;
                dec_imm    = imm_b;
                dec_rd     = 5'd0;
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_JAL: begin
                dec_jump       = 1'b1;
                dec_reg_write  = 1'b1;
                dec_src_a      = 1'b1;
                dec_src_b      = 1'b1;
                dec_imm        = imm_j;
                dec_result_src = RES_NPC;
            end
            OPC_JALR: begin
                dec_jump       = 1'b1;
                dec_reg_write  = 1'b1;
                dec_src_b      = 1'b1;
                dec_imm        = imm_i;
                dec_result_src = RES_NPC;
                if (funct3 != 3'd0) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_reg_write = 1'b1;
                dec_src_b     = 1'b1;
                dec_imm       = imm_u;
                dec_alu       = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_src_a     = 1'b1;
                dec_src_b     = 1'b1;
                dec_imm       = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec_alu        = ALU_ADD;
            dec_src_a      = 1'b0;
            dec_src_b      = 1'b0;
            dec_reg_write  = 1'b0;
            dec_mem_read   = 1'b0;
            dec_mem_write  = 1'b0;
            dec_branch     = 1'b0;
            dec_jump       = 1'b0;
            dec_result_src = RES_ALU;
            dec_imm        = '0;
        end
    end

    // Decode->exec pipeline register: flush inserts a bubble, stall holds, else load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            if (!rst_n || flush) begin
                rs1_data_exec   <= '0;
                rs2_data_exec   <= '0;
                imm_exec        <= '0;
                rs1_exec        <= '0;
                rs2_exec        <= '0;
                rd_exec         <= '0;
                pc_exec         <= RESET_PC;
                next_pc_exec    <= RESET_PC;
                funct3_exec     <= '0;
                alu_ctrl_exec   <= '0;
                alu_src_a_exec  <= 1'b0;
                alu_src_b_exec  <= 1'b0;
                reg_write_exec  <= 1'b0;
                mem_read_exec   <= 1'b0;
                mem_write_exec  <= 1'b0;
                branch_exec     <= 1'b0;
                jump_exec       <= 1'b0;
                result_src_exec <= '0;
                valid_exec      <= 1'b0;
                illegal_exec    <= 1'b0;
            end
        end else if (!stall) begin
            rs1_data_exec   <= rs1_val;
            rs2_data_exec   <= rs2_val;
            imm_exec        <= dec_imm;
            rs1_exec        <= rs1;
            rs2_exec        <= rs2;
            rd_exec         <= dec_rd;
            pc_exec         <= pc_fetch;
            next_pc_exec    <= next_pc_fetch;
            funct3_exec     <= funct3;
            alu_ctrl_exec   <= dec_alu;
            alu_src_a_exec  <= dec_src_a;
            alu_src_b_exec  <= dec_src_b;
            reg_write_exec  <= dec_reg_write;
            mem_read_exec   <= dec_mem_read;
            mem_write_exec  <= dec_mem_write;
            branch_exec     <= dec_branch;
            jump_exec       <= dec_jump;
            result_src_exec <= dec_result_src;
            valid_exec      <= 1'b1;
            illegal_exec    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed vector table, multi-cycle
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_instr_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_fetch;
    logic [31:0] pc_fetch;
    logic [31:0] next_pc_fetch;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1_data_exec;
    logic [31:0] rs2_data_exec;
    logic [31:0] imm_exec;
    logic [4:0]  rs1_exec;
    logic [4:0]  rs2_exec;
    logic [4:0]  rd_exec;
    logic [31:0] pc_exec;
    logic [31:0] next_pc_exec;
    logic [2:0]  funct3_exec;
    logic [3:0]  alu_ctrl_exec;
    logic        alu_src_a_exec;
    logic        alu_src_b_exec;
    logic        reg_write_exec;
    logic        mem_read_exec;
    logic        mem_write_exec;
    logic        branch_exec;
    logic        jump_exec;
    logic [1:0]  result_src_exec;
    logic        valid_exec;
    logic        illegal_exec;

    instr_decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_fetch(instr_fetch), .pc_fetch(pc_fetch), .next_pc_fetch(next_pc_fetch),
        .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_data_exec(rs1_data_exec), .rs2_data_exec(rs2_data_exec), .imm_exec(imm_exec),
        .rs1_exec(rs1_exec), .rs2_exec(rs2_exec), .rd_exec(rd_exec),
        .pc_exec(pc_exec), .next_pc_exec(next_pc_exec), .funct3_exec(funct3_exec),
        .alu_ctrl_exec(alu_ctrl_exec), .alu_src_a_exec(alu_src_a_exec),
        .alu_src_b_exec(alu_src_b_exec), .reg_write_exec(reg_write_exec),
        .mem_read_exec(mem_read_exec), .mem_write_exec(mem_write_exec),
        .branch_exec(branch_exec), .jump_exec(jump_exec),
        .result_src_exec(result_src_exec), .valid_exec(valid_exec),
        .illegal_exec(illegal_exec)
    );

    typedef struct {
        logic [31:0] rs1_data, rs2_data, imm, pc, npc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic [3:0]  alu;
        logic        src_a, src_b, rw, mr, mw, br, jp;
        logic [1:0]  res;
        logic        valid, illegal;
    } dec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src_b, rw, br, illegal;
        logic [31:0] rs1d, rs2d;
    } vec_t;

    int          checks;
    int          errors;
    dec_t        exp_q;
    logic [31:0] ref_regs [32];
    logic [31:0] pc_ctr;
    vec_t        vecs [10];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic dec_t bubble();
        dec_t d;
        d = '{default: '0};
        d.pc  = RESET_PC;
        d.npc = RESET_PC;
        return d;
    endfunction

    // Reference decoder built from the ISA rules: immediates by arithmetic,
    // ALU code by funct3 lookup plus one for the SUB/SRA alternates
    function automatic dec_t decode_ref(input logic [31:0] i, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] pc,
                                        input logic [31:0] npc);
        dec_t        d;
        logic [3:0]  alu_base [8];
        logic [31:0] sx, imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        ok;
        alu_base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        d  = bubble();
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        sx = {32{i[31]}};
        imm_i = $signed(i) >>> 20;
        imm_s = (sx << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
        imm_b = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_u = i & 32'hFFFF_F000;
        imm_j = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        d.valid = 1'b1;
        d.pc = pc;
        d.npc = npc;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd = i[11:7];
        d.funct3 = f3;
        d.rs1_data = a;
        d.rs2_data = b;
        ok = 1'b1;
        case (op)
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                d.alu = alu_base[f3] + 4'(f7[5]);
                d.rw = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                d.alu = alu_base[f3] + ((f3 == 3'd5) ? 4'(f7[5]) : 4'd0);
                d.rw = 1'b1; d.src_b = 1'b1; d.imm = imm_i;
            end
            7'h03: begin
                ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                d.rw = 1'b1; d.mr = 1'b1; d.src_b = 1'b1; d.imm = imm_i; d.res = 2'b01;
            end
            7'h23: begin
                ok = (f3 <= 3'd2);
                d.mw = 1'b1; d.src_b = 1'b1; d.imm = imm_s; d.rd = 5'd0;
            end
            7'h63: begin
                ok = (f3 != 3'd2 && f3 != 3'd3);
                d.br = 1'b1; d.alu = 4'd1; d.imm = imm_b; d.rd = 5'd0;
            end
            7'h6F: begin
                d.jp = 1'b1; d.rw = 1'b1; d.src_a = 1'b1; d.src_b = 1'b1;
                d.imm = imm_j; d.res = 2'b10;
            end
            7'h67: begin
                ok = (f3 == 3'd0);
                d.jp = 1'b1; d.rw = 1'b1; d.src_b = 1'b1; d.imm = imm_i; d.res = 2'b10;
            end
            7'h37: begin
                d.rw = 1'b1; d.src_b = 1'b1; d.imm = imm_u; d.alu = 4'd10;
            end
            7'h17: begin
                d.rw = 1'b1; d.src_a = 1'b1; d.src_b = 1'b1; d.imm = imm_u;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d.alu = 4'd0; d.src_a = 1'b0; d.src_b = 1'b0; d.rw = 1'b0; d.mr = 1'b0;
            d.mw = 1'b0; d.br = 1'b0; d.jp = 1'b0; d.res = 2'b00; d.imm = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    // Model register read: x0 is zero, a same-cycle write wins over the array
    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wrd == idx) return wd;
        return ref_regs[idx];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r   = $urandom;
        sel = $urandom_range(0, 10);
        if (sel < 9) begin
            r[6:0] = ops[sel];
            if (ops[sel] == 7'h33 || (ops[sel] == 7'h13 && r[13:12] == 2'b01)) begin
                r[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
            end
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) ref_regs[k] = 32'd0;
        exp_q = bubble();
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model at the rising edge
    task automatic applyStimulus(input logic [31:0] instr, input logic st, input logic fl,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        dec_t pred;
        @(negedge clk);
        instr_fetch   = instr;
        pc_fetch      = pc_ctr;
        next_pc_fetch = pc_ctr + 32'd4;
        stall         = st;
        flush         = fl;
        wb_en         = we;
        wb_rd         = wrd;
        wb_data       = wd;
        pred = decode_ref(instr, ref_read(instr[19:15], we, wrd, wd),
                          ref_read(instr[24:20], we, wrd, wd), pc_ctr, pc_ctr + 32'd4);
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        if (we && wrd != 5'd0) ref_regs[wrd] = wd;
        if (fl)       exp_q = bubble();
        else if (!st) exp_q = pred;
        #1;
    endtask

    // Compare every DUT output against the model; data fields are unspecified for illegal words
    task automatic checkOutput(input string tag);
        cmp({tag, ".valid"},   32'(valid_exec),      32'(exp_q.valid));
        cmp({tag, ".illegal"}, 32'(illegal_exec),    32'(exp_q.illegal));
        cmp({tag, ".pc"},      pc_exec,              exp_q.pc);
        cmp({tag, ".npc"},     next_pc_exec,         exp_q.npc);
        cmp({tag, ".alu"},     32'(alu_ctrl_exec),   32'(exp_q.alu));
        cmp({tag, ".ctl"},
            32'({alu_src_a_exec, alu_src_b_exec, reg_write_exec, mem_read_exec,
                 mem_write_exec, branch_exec, jump_exec, result_src_exec}),
            32'({exp_q.src_a, exp_q.src_b, exp_q.rw, exp_q.mr, exp_q.mw,
                 exp_q.br, exp_q.jp, exp_q.res}));
        if (!exp_q.illegal) begin
            cmp({tag, ".imm"},    imm_exec,            exp_q.imm);
            cmp({tag, ".rs1"},    32'(rs1_exec),       32'(exp_q.rs1));
            cmp({tag, ".rs2"},    32'(rs2_exec),       32'(exp_q.rs2));
            cmp({tag, ".rd"},     32'(rd_exec),        32'(exp_q.rd));
            cmp({tag, ".funct3"}, 32'(funct3_exec),    32'(exp_q.funct3));
            cmp({tag, ".rs1d"},   rs1_data_exec,       exp_q.rs1_data);
            cmp({tag, ".rs2d"},   rs2_data_exec,       exp_q.rs2_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc_ctr = 32'h0000_0100;
        rst_n = 1'b0;
        instr_fetch = '0; pc_fetch = '0; next_pc_fetch = '0;
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        model_reset();

        vecs[0] = '{name:"addi", instr:32'h00500093, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:1, imm:5, alu:0, src_b:1, rw:1, br:0, illegal:0, rs1d:0, rs2d:0};
        vecs[1] = '{name:"bypass", instr:32'h00108133, wb_en:1, wb_rd:1, wb_data:32'hDEADBEEF,
                    chk_data:1, rd:2, imm:0, alu:0, src_b:0, rw:1, br:0, illegal:0,
                    rs1d:32'hDEADBEEF, rs2d:32'hDEADBEEF};
        vecs[2] = '{name:"x0", instr:32'h00000233, wb_en:1, wb_rd:0, wb_data:32'h1234, chk_data:1,
                    rd:4, imm:0, alu:0, src_b:0, rw:1, br:0, illegal:0, rs1d:0, rs2d:0};
        vecs[3] = '{name:"beq", instr:32'hFE000CE3, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:0, imm:32'hFFFFFFF8, alu:1, src_b:0, rw:0, br:1, illegal:0, rs1d:0, rs2d:0};
        vecs[4] = '{name:"sub", instr:32'h40008333, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:6, imm:0, alu:1, src_b:0, rw:1, br:0, illegal:0,
                    rs1d:32'hDEADBEEF, rs2d:0};
        vecs[5] = '{name:"lui", instr:32'h123453B7, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:7, imm:32'h12345000, alu:10, src_b:1, rw:1, br:0, illegal:0, rs1d:0, rs2d:0};
        vecs[6] = '{name:"srai", instr:32'h4030D413, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:8, imm:32'h403, alu:7, src_b:1, rw:1, br:0, illegal:0,
                    rs1d:32'hDEADBEEF, rs2d:0};
        vecs[7] = '{name:"sw", instr:32'h0020A423, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:0, imm:8, alu:0, src_b:1, rw:0, br:0, illegal:0,
                    rs1d:32'hDEADBEEF, rs2d:0};
        vecs[8] = '{name:"jal", instr:32'h010000EF, wb_en:0, wb_rd:0, wb_data:0, chk_data:1,
                    rd:1, imm:16, alu:0, src_b:1, rw:1, br:0, illegal:0, rs1d:0, rs2d:0};
        vecs[9] = '{name:"illegal", instr:32'hFFFFFFFF, wb_en:0, wb_rd:0, wb_data:0, chk_data:0,
                    rd:0, imm:0, alu:0, src_b:0, rw:0, br:0, illegal:1, rs1d:0, rs2d:0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        #2 rst_n = 1'b1;

        for (int n = 0; n < 10; n++) begin
            applyStimulus(vecs[n].instr, 1'b0, 1'b0, vecs[n].wb_en, vecs[n].wb_rd, vecs[n].wb_data);
            checkOutput(vecs[n].name);
            cmp({vecs[n].name, ".h_valid"},   32'(valid_exec),     32'd1);
            cmp({vecs[n].name, ".h_illegal"}, 32'(illegal_exec),   32'(vecs[n].illegal));
            cmp({vecs[n].name, ".h_alu"},     32'(alu_ctrl_exec),  32'(vecs[n].alu));
            cmp({vecs[n].name, ".h_srcb"},    32'(alu_src_b_exec), 32'(vecs[n].src_b));
            cmp({vecs[n].name, ".h_rw"},      32'(reg_write_exec), 32'(vecs[n].rw));
            cmp({vecs[n].name, ".h_br"},      32'(branch_exec),    32'(vecs[n].br));
            if (vecs[n].chk_data) begin
                cmp({vecs[n].name, ".h_rd"},   32'(rd_exec),  32'(vecs[n].rd));
                cmp({vecs[n].name, ".h_imm"},  imm_exec,      vecs[n].imm);
                cmp({vecs[n].name, ".h_rs1d"}, rs1_data_exec, vecs[n].rs1d);
                cmp({vecs[n].name, ".h_rs2d"}, rs2_data_exec, vecs[n].rs2d);
            end
        end

        // Stall holds the loaded addi for two cycles, then flush beats stall
        applyStimulus(32'h00500093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("preload");
        for (int n = 0; n < 2; n++) begin
            applyStimulus(32'h40008333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            checkOutput("stall");
            cmp("stall.h_imm", imm_exec, 32'd5);
            cmp("stall.h_rd", 32'(rd_exec), 32'd1);
            cmp("stall.h_alu", 32'(alu_ctrl_exec), 32'd0);
        end
        applyStimulus(32'h40008333, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        checkOutput("flush");
        cmp("flush.h_valid", 32'(valid_exec), 32'd0);
        cmp("flush.h_rw", 32'(reg_write_exec), 32'd0);
        cmp("flush.h_pc", pc_exec, RESET_PC);

        // Write x5=7, confirm it, then reset mid-cycle and confirm x5 is cleared
        applyStimulus(32'h00000013, 1'b0, 1'b0, 1'b1, 5'd5, 32'd7);
        checkOutput("wr_x5");
        applyStimulus(32'h000284B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("rd_x5");
        cmp("rd_x5.h_rs1d", rs1_data_exec, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("midreset");
        cmp("midreset.h_valid", 32'(valid_exec), 32'd0);
        cmp("midreset.h_rs1d", rs1_data_exec, 32'd0);
        rst_n = 1'b1;
        applyStimulus(32'h000284B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("after_rst");
        cmp("after_rst.h_rs1d", rs1_data_exec, 32'd0);
        cmp("after_rst.h_valid", 32'(valid_exec), 32'd1);

        // Randomized traffic with stalls, flushes and writebacks, some aimed at rs1
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            logic [4:0]  wrd;
            ins = rand_instr();
            wrd = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31));
            applyStimulus(ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)), wrd, $urandom);
            checkOutput("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
